// File: rtl/nvi_int_seq_if.sv
// Interrupt-controller handshake plus Naive-Memory push port of the interrupt sequencer.
// master = sequencer side, slave = intc/memory side.
interface nvi_int_seq_if;
  logic        int_req_n;
  logic [7:0]  int_so_num;
  logic        int_ack_n;
  logic        int_reti;
  logic        mem_sel;
  logic [15:0] mem_addr;
  logic        mem_we_n;
  logic        mem_rd_n;
  logic        mem_sfr_n;
  logic [7:0]  mem_wdata;
  logic        mem_ready_in;

  modport master (
    input  int_req_n, int_so_num, mem_ready_in,
    output int_ack_n, int_reti, mem_sel, mem_addr, mem_we_n, mem_rd_n, mem_sfr_n, mem_wdata
  );

  modport slave (
    output int_req_n, int_so_num, mem_ready_in,
    input  int_ack_n, int_reti, mem_sel, mem_addr, mem_we_n, mem_rd_n, mem_sfr_n, mem_wdata
  );
endinterface

// File: rtl/nvi_int_seq.sv
// CPU-side interrupt entry sequencer: accept -> ack -> push PC (2 bytes) -> load vector -> wait RETI.
// Latency accept->pc_load = 3+ACK_WIDTH cycles plus memory waits; pushes hold until mem_ready_in. Option: INTSEQ_RETI_BLOCK_EN.
module nvi_int_seq #(
  parameter logic [7:0] VEC_HI    = 8'h00,
  parameter int         ACK_WIDTH = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  nvi_int_seq_if.master bus,
  input  logic          instr_boundary,
  input  logic          reti_exec,
  input  logic [15:0]   cur_pc,
  input  logic [7:0]    sp_in,
  output logic          core_stall,
  output logic          pc_load,
  output logic [15:0]   pc_load_val,
  output logic          sp_we,
  output logic [7:0]    sp_wdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_PUSH_L, S_PUSH_H, S_LOAD, S_ISR
  } state_t;

  localparam logic [1:0] ACK_LAST = 2'(ACK_WIDTH - 1);

  state_t      state, state_nx;
  logic [15:0] pc_q;
  logic [7:0]  sp_q;
  logic [7:0]  vec_q;
  logic [1:0]  ack_cnt;
  logic        reti_q;
  logic        blocked;
  logic        accept;
  logic        ack_last;
  logic        reti_fire;

  assign ack_last  = (state == S_ACK) && (ack_cnt == ACK_LAST);
  assign reti_fire = (state == S_ISR) && reti_exec;
  assign accept    = (state == S_IDLE) && !bus.int_req_n && instr_boundary && !blocked;

`ifdef INTSEQ_RETI_BLOCK_EN
  // One full instruction must run after RETI before another entry is taken.
  logic blk_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      blk_q <= 1'b0;
    else if (reti_fire)
      blk_q <= 1'b1;
    else if (state == S_IDLE && instr_boundary)
      blk_q <= 1'b0;
  end
  assign blocked = blk_q;
`else
  assign blocked = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept)           state_nx = S_ACK;
      S_ACK:    if (ack_last)         state_nx = S_PUSH_L;
      S_PUSH_L: if (bus.mem_ready_in) state_nx = S_PUSH_H;
      S_PUSH_H: if (bus.mem_ready_in) state_nx = S_LOAD;
      S_LOAD:                         state_nx = S_ISR;
      S_ISR:    if (reti_exec)        state_nx = S_IDLE;
      default:                        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= 16'h0000;
      sp_q    <= 8'h00;
      vec_q   <= 8'h00;
      ack_cnt <= 2'd0;
      reti_q  <= 1'b0;
    end else begin
      if (accept) begin
        pc_q <= cur_pc;
        sp_q <= sp_in;
      end
      ack_cnt <= (state == S_ACK) ? ack_cnt + 2'd1 : 2'd0;
      // Vector sampled while intc is guaranteed to still drive it.
      if (ack_last)
        vec_q <= bus.int_so_num;
      reti_q <= reti_fire;
    end
  end

  assign bus.int_ack_n  = (state != S_ACK);
  assign bus.int_reti   = reti_q;
  assign core_stall     = (state == S_ACK) || (state == S_PUSH_L) ||
                          (state == S_PUSH_H) || (state == S_LOAD);
  assign pc_load        = (state == S_LOAD);
  assign pc_load_val    = pc_load ? {VEC_HI, vec_q} : 16'h0000;
  assign sp_we          = (state == S_LOAD);
  assign sp_wdata       = sp_we ? sp_q + 8'd2 : 8'h00;
  assign bus.mem_sel    = (state == S_PUSH_L) || (state == S_PUSH_H);
  assign bus.mem_we_n   = !bus.mem_sel;
  assign bus.mem_rd_n   = 1'b1;
  assign bus.mem_sfr_n  = 1'b1;
  assign bus.mem_addr   = (state == S_PUSH_L) ? {8'h00, sp_q + 8'd1} :
                          (state == S_PUSH_H) ? {8'h00, sp_q + 8'd2} : 16'h0000;
  assign bus.mem_wdata  = (state == S_PUSH_L) ? pc_q[7:0]  :
                          (state == S_PUSH_H) ? pc_q[15:8] : 8'h00;

endmodule
